id_inflight_tracker: RTL and testbench

- Tracks which transaction IDs are in flight for the issue/retire path.
- Allocates the lowest free ID on request and decodes integer retire IDs back into a one-hot in-flight vector.
- Sits between the issue logic, which allocates IDs, and the writeback/retire logic, which returns IDs as integers.
- Provides registered one-hot and count views to downstream one-hot consumers.

---
 rtl/id_inflight_tracker_if.sv | 50 +++++
 rtl/id_inflight_tracker.sv | 105 ++++++++++
 tb/tb_id_inflight_tracker.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/id_inflight_tracker_if.sv
// Issue/retire handshake bundle for the in-flight ID tracker.
// The slave modport is the tracker's side. The master modport is the issue/retire side.
interface id_inflight_tracker_if #(
    parameter int NUM_IDS = 8
);
    localparam int ID_W = (NUM_IDS == 1) ? 1 : $clog2(NUM_IDS);

    logic                 alloc_valid;
    logic                 alloc_ready;
    logic [ID_W-1:0]      alloc_id;
    logic [NUM_IDS-1:0]   alloc_onehot;
    logic                 retire_valid;
    logic [ID_W-1:0]      retire_id;
    logic [NUM_IDS-1:0]   retire_onehot;
    logic [NUM_IDS-1:0]   inflight;
    logic [ID_W:0]        inflight_count;
    logic                 empty;
    logic                 full;
    logic                 retire_err;

    modport slave (
        input  alloc_valid,
        input  retire_valid,
        input  retire_id,
        output alloc_ready,
        output alloc_id,
        output alloc_onehot,
        output retire_onehot,
        output inflight,
        output inflight_count,
        output empty,
        output full,
        output retire_err
    );

    modport master (
        output alloc_valid,
        output retire_valid,
        output retire_id,
        input  alloc_ready,
        input  alloc_id,
        input  alloc_onehot,
        input  retire_onehot,
        input  inflight,
        input  inflight_count,
        input  empty,
        input  full,
        input  retire_err
    );
endinterface

// File: rtl/id_inflight_tracker.sv
// In-flight transaction ID tracker.
// Allocation hands out the lowest free ID. Retire takes back an integer ID.
// The tracker keeps a registered one-hot in-flight set and its population count.
// Illegal retires leave the state unchanged and set a sticky error flag.
module id_inflight_tracker #(
    parameter int NUM_IDS = 8
) (
    input  logic                  clk,
    input  logic                  rst,     // asynchronous, active low
    id_inflight_tracker_if.slave  bus
);
    localparam int ID_W  = (NUM_IDS == 1) ? 1 : $clog2(NUM_IDS);
    localparam int CNT_W = ID_W + 1;

    logic [NUM_IDS-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [NUM_IDS-1:0] retire_onehot_q, retire_onehot_d;
    logic               retire_err_q, retire_err_d;

    logic [NUM_IDS-1:0] alloc_onehot_c;
    logic [ID_W-1:0]    alloc_id_c;
    logic [NUM_IDS-1:0] retire_dec_c;
    logic               full_c;
    logic               retire_in_range_c;
    logic               retire_hit_c;
    logic               alloc_fire_c;

    // Lowest clear bit of the in-flight set. The result is all-zero when full, because the +1 then wraps to 0.
    assign alloc_onehot_c = ~inflight_q & (inflight_q + NUM_IDS'(1));
    assign full_c         = &inflight_q;

    // Encode the one-hot free ID back to an integer; at most one bit is set.
    always_comb begin
        alloc_id_c = '0;
        for (int i = 0; i < NUM_IDS; i++) begin
            if (alloc_onehot_c[i]) begin
                alloc_id_c = alloc_id_c | ID_W'(i);
            end
        end
    end

    // Decode the integer retire ID. IDs at NUM_IDS or above decode to no bit at all.
    generate
        for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_retire_dec
            assign retire_dec_c[gi] = (bus.retire_id == ID_W'(gi));
        end
    endgenerate

    assign retire_in_range_c = ({1'b0, bus.retire_id} < CNT_W'(NUM_IDS));
    assign retire_hit_c      = bus.retire_valid && retire_in_range_c
                               && ((retire_dec_c & inflight_q) != '0);
    assign alloc_fire_c      = bus.alloc_valid && !full_c;

    // Next-state logic. The alloc target is always a free bit and the retire target is always an in-flight bit.
    // The two updates therefore never collide, and a retired ID cannot be handed out again in the same cycle.
    always_comb begin
        inflight_d      = inflight_q;
        count_d         = count_q;
        retire_onehot_d = '0;
        retire_err_d    = retire_err_q;

        if (retire_hit_c) begin
            inflight_d      = inflight_d & ~retire_dec_c;
            retire_onehot_d = retire_dec_c;
        end
        if (alloc_fire_c) begin
            inflight_d = inflight_d | alloc_onehot_c;
        end

        case ({alloc_fire_c, retire_hit_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (bus.retire_valid && !retire_hit_c) begin
            retire_err_d = 1'b1;
        end
    end

    // State registers; reset clears everything at once, independent of clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q      <= '0;
            count_q         <= '0;
            retire_onehot_q <= '0;
            retire_err_q    <= 1'b0;
        end else begin
            inflight_q      <= inflight_d;
            count_q         <= count_d;
            retire_onehot_q <= retire_onehot_d;
            retire_err_q    <= retire_err_d;
        end
    end

    assign bus.alloc_ready    = ~full_c;
    assign bus.alloc_id       = alloc_id_c;
    assign bus.alloc_onehot   = alloc_onehot_c;
    assign bus.retire_onehot  = retire_onehot_q;
    assign bus.inflight       = inflight_q;
    assign bus.inflight_count = count_q;
    assign bus.empty          = (inflight_q == '0);
    assign bus.full           = full_c;
    assign bus.retire_err     = retire_err_q;
endmodule

// File: tb/tb_id_inflight_tracker.sv
// Directed bench for id_inflight_tracker with NUM_IDS = 4, 6 and 1.
module tb_id_inflight_tracker;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    id_inflight_tracker_if #(.NUM_IDS(4)) if4 ();
    id_inflight_tracker_if #(.NUM_IDS(6)) if6 ();
    id_inflight_tracker_if #(.NUM_IDS(1)) if1 ();

    id_inflight_tracker #(.NUM_IDS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    id_inflight_tracker #(.NUM_IDS(6)) dut6 (.clk(clk), .rst(rst), .bus(if6.slave));
    id_inflight_tracker #(.NUM_IDS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    typedef struct packed {
        logic       av;
        logic       rv;
        logic [1:0] rid;
        logic [3:0] inf;
        logic [2:0] cnt;
        logic [3:0] ro;
        logic       chk_aid;
        logic [1:0] aid;
        logic       rdy;
        logic       emp;
        logic       ful;
        logic       err;
    } vec_t;

    vec_t vec4 [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        if4.alloc_valid = 0; if4.retire_valid = 0; if4.retire_id = '0;
        if6.alloc_valid = 0; if6.retire_valid = 0; if6.retire_id = '0;
        if1.alloc_valid = 0; if1.retire_valid = 0; if1.retire_id = '0;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        idle_all();

        //        av rv rid inf      cnt ro       ca aid rdy emp ful err
        vec4[0]  = '{1'b1, 1'b0, 2'd0, 4'b0001, 3'd1, 4'b0000, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        vec4[1]  = '{1'b1, 1'b0, 2'd0, 4'b0011, 3'd2, 4'b0000, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vec4[2]  = '{1'b1, 1'b0, 2'd0, 4'b0111, 3'd3, 4'b0000, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        vec4[3]  = '{1'b1, 1'b0, 2'd0, 4'b1111, 3'd4, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vec4[4]  = '{1'b1, 1'b0, 2'd0, 4'b1111, 3'd4, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vec4[5]  = '{1'b0, 1'b1, 2'd2, 4'b1011, 3'd3, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vec4[6]  = '{1'b1, 1'b0, 2'd0, 4'b1111, 3'd4, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vec4[7]  = '{1'b1, 1'b1, 2'd0, 4'b1110, 3'd3, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec4[8]  = '{1'b1, 1'b0, 2'd0, 4'b1111, 3'd4, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vec4[9]  = '{1'b0, 1'b1, 2'd3, 4'b0111, 3'd3, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        vec4[10] = '{1'b0, 1'b1, 2'd2, 4'b0011, 3'd2, 4'b0100, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vec4[11] = '{1'b1, 1'b1, 2'd0, 4'b0110, 3'd2, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vec4[12] = '{1'b0, 1'b1, 2'd0, 4'b0110, 3'd2, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        vec4[13] = '{1'b0, 1'b0, 2'd0, 4'b0110, 3'd2, 4'b0000, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1};

        do_reset();

        // Reset state, NUM_IDS=4
        chk("rst_inflight", if4.inflight, 4'b0000);
        chk("rst_count", if4.inflight_count, 3'd0);
        chk("rst_retire_onehot", if4.retire_onehot, 4'b0000);
        chk("rst_err", if4.retire_err, 1'b0);
        chk("rst_empty", if4.empty, 1'b1);
        chk("rst_full", if4.full, 1'b0);
        chk("rst_ready", if4.alloc_ready, 1'b1);
        chk("rst_alloc_id", if4.alloc_id, 2'd0);
        chk("rst_alloc_onehot", if4.alloc_onehot, 4'b0001);

        // Table-driven sequence on the 4-ID tracker
        for (int i = 0; i < 14; i++) begin
            if4.alloc_valid  = vec4[i].av;
            if4.retire_valid = vec4[i].rv;
            if4.retire_id    = vec4[i].rid;
            tick();
            idle_all();
            $display("vec %0d: av=%0b rv=%0b rid=%0d -> inflight=%b count=%0d ro=%b err=%0b",
                     i, vec4[i].av, vec4[i].rv, vec4[i].rid,
                     if4.inflight, if4.inflight_count, if4.retire_onehot, if4.retire_err);
            chk($sformatf("v%0d_inflight", i), if4.inflight, vec4[i].inf);
            chk($sformatf("v%0d_count", i), if4.inflight_count, vec4[i].cnt);
            chk($sformatf("v%0d_retire_onehot", i), if4.retire_onehot, vec4[i].ro);
            chk($sformatf("v%0d_ready", i), if4.alloc_ready, vec4[i].rdy);
            chk($sformatf("v%0d_empty", i), if4.empty, vec4[i].emp);
            chk($sformatf("v%0d_full", i), if4.full, vec4[i].ful);
            chk($sformatf("v%0d_err", i), if4.retire_err, vec4[i].err);
            chk($sformatf("v%0d_invariant", i), if4.inflight_count, $countones(if4.inflight));
            if (vec4[i].chk_aid) begin
                chk($sformatf("v%0d_alloc_id", i), if4.alloc_id, vec4[i].aid);
                chk($sformatf("v%0d_alloc_onehot", i), if4.alloc_onehot, 4'b0001 << vec4[i].aid);
            end else begin
                chk($sformatf("v%0d_alloc_onehot_full", i), if4.alloc_onehot, 4'b0000);
            end
        end

        // Mid-stream asynchronous reset with inflight=0101 and err set
        do_reset();
        repeat (3) begin
            if4.alloc_valid = 1;
            tick();
        end
        if4.alloc_valid = 0;
        if4.retire_valid = 1; if4.retire_id = 2'd1;
        tick();
        if4.retire_id = 2'd3;
        tick();
        if4.retire_valid = 0;
        $display("midrst setup: inflight=%b err=%0b", if4.inflight, if4.retire_err);
        chk("midrst_pre_inflight", if4.inflight, 4'b0101);
        chk("midrst_pre_err", if4.retire_err, 1'b1);
        if4.alloc_valid = 1;
        #2 rst = 1'b0;
        #1;
        $display("midrst asserted: inflight=%b count=%0d err=%0b", if4.inflight, if4.inflight_count, if4.retire_err);
        chk("midrst_inflight", if4.inflight, 4'b0000);
        chk("midrst_count", if4.inflight_count, 3'd0);
        chk("midrst_err", if4.retire_err, 1'b0);
        chk("midrst_empty", if4.empty, 1'b1);
        if4.alloc_valid = 0;
        #2 rst = 1'b1;
        tick();
        $display("midrst released: alloc_id=%0d empty=%0b err=%0b", if4.alloc_id, if4.empty, if4.retire_err);
        chk("postrst_alloc_id", if4.alloc_id, 2'd0);
        chk("postrst_empty", if4.empty, 1'b1);
        chk("postrst_err", if4.retire_err, 1'b0);
        chk("postrst_inflight", if4.inflight, 4'b0000);

        // NUM_IDS=6: out-of-range retire leaves state unchanged
        do_reset();
        repeat (2) begin
            if6.alloc_valid = 1;
            tick();
        end
        if6.alloc_valid = 0;
        if6.retire_valid = 1; if6.retire_id = 3'd7;
        tick();
        if6.retire_valid = 0;
        $display("n6 retire 7: inflight=%b ro=%b err=%0b", if6.inflight, if6.retire_onehot, if6.retire_err);
        chk("n6_oor_err", if6.retire_err, 1'b1);
        chk("n6_oor_inflight", if6.inflight, 6'b000011);
        chk("n6_oor_ro", if6.retire_onehot, 6'b000000);
        chk("n6_oor_count", if6.inflight_count, 4'd2);

        // NUM_IDS=6: retire of a non-inflight ID straight after reset
        do_reset();
        chk("n6_rst_err", if6.retire_err, 1'b0);
        if6.retire_valid = 1; if6.retire_id = 3'd4;
        tick();
        if6.retire_valid = 0;
        $display("n6 retire 4 idle: inflight=%b err=%0b", if6.inflight, if6.retire_err);
        chk("n6_notinf_err", if6.retire_err, 1'b1);
        chk("n6_notinf_inflight", if6.inflight, 6'b000000);

        // NUM_IDS=6: fill to full, then retire the top ID
        do_reset();
        repeat (6) begin
            if6.alloc_valid = 1;
            tick();
        end
        if6.alloc_valid = 0;
        $display("n6 filled: inflight=%b count=%0d full=%0b", if6.inflight, if6.inflight_count, if6.full);
        chk("n6_full_count", if6.inflight_count, 4'd6);
        chk("n6_full_flag", if6.full, 1'b1);
        chk("n6_full_ready", if6.alloc_ready, 1'b0);
        if6.retire_valid = 1; if6.retire_id = 3'd5;
        tick();
        if6.retire_valid = 0;
        $display("n6 retire 5: inflight=%b ro=%b alloc_id=%0d", if6.inflight, if6.retire_onehot, if6.alloc_id);
        chk("n6_top_ro", if6.retire_onehot, 6'b100000);
        chk("n6_top_inflight", if6.inflight, 6'b011111);
        chk("n6_top_alloc_id", if6.alloc_id, 3'd5);
        tick();
        chk("n6_top_ro_pulse", if6.retire_onehot, 6'b000000);

        // NUM_IDS=1: single ID, retire_id=1 is illegal
        do_reset();
        chk("n1_rst_alloc_onehot", if1.alloc_onehot, 1'b1);
        if1.alloc_valid = 1;
        tick();
        if1.alloc_valid = 0;
        chk("n1_full", if1.full, 1'b1);
        chk("n1_count", if1.inflight_count, 2'd1);
        if1.retire_valid = 1; if1.retire_id = 1'b1;
        tick();
        $display("n1 retire 1: inflight=%b err=%0b", if1.inflight, if1.retire_err);
        chk("n1_oor_err", if1.retire_err, 1'b1);
        chk("n1_oor_inflight", if1.inflight, 1'b1);
        if1.retire_id = 1'b0;
        tick();
        if1.retire_valid = 0;
        $display("n1 retire 0: inflight=%b ro=%b", if1.inflight, if1.retire_onehot);
        chk("n1_ret_inflight", if1.inflight, 1'b0);
        chk("n1_ret_ro", if1.retire_onehot, 1'b1);
        chk("n1_ret_empty", if1.empty, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
